// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(12,8) transmit serializer.
// Optional build macro: HAMMING_SECDED_EN appends an overall even-parity bit,
// which makes the serial frame 13 bits long.
package hamming_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = 12;

`ifdef HAMMING_SECDED_EN
    localparam int FRAME_LEN = CODE_W + 1;
`else
    localparam int FRAME_LEN = CODE_W;
`endif

    // Codeword position of data bit d[i], i = 1..8.
    localparam int DATA_POS [1:DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};
    // Parity bit k sits at position 2**k and covers every position with bit k set.
    localparam int PARITY_POS [0:3] = '{1, 2, 4, 8};

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

    // Scatter data into its positions, then fill each parity position with the
    // even parity of the positions it covers.
    function automatic logic [CODE_W:1] hamming_encode(input logic [DATA_W:1] d);
        logic [CODE_W:1] c;
        logic            p;
        c = '0;
        for (int i = 1; i <= DATA_W; i++) begin
            c[DATA_POS[i]] = d[i];
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j <= CODE_W; j++) begin
                if (((j >> k) & 1) == 1 && j != PARITY_POS[k]) begin
                    p = p ^ c[j];
                end
            end
            c[PARITY_POS[k]] = p;
        end
        return c;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(12,8) encoder: data d[8:1] -> codeword c[12:1].
// Also serves as the reference encoder in the decoder's bench.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W:1] data_i,
    output logic [CODE_W:1] code_o
);

    assign code_o = hamming_encode(data_i);

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(12,8) transmit serializer: accepts bytes over valid/ready, encodes
// them and shifts the codeword out one bit per accepted beat with sof/eof.
// A one-entry holding register lets the next frame follow with no bubble.
// Optional build macro: HAMMING_SECDED_EN (13-bit frame with overall parity).
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int GAP       = 0,    // idle cycles after each eof (0..15)
    parameter bit MSB_FIRST = 1'b0  // 0: codeword bit 1 first, 1: top bit first
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx_bit_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_sof_o,
    output logic        tx_eof_o,
    output logic [11:0] code_o,
    output logic        busy_o
);

    localparam int         FL       = FRAME_LEN;
    localparam logic [3:0] LAST_CNT = 4'(FL - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    // The GAP parameter hides the GAP state name from the wildcard import,
    // so the state is always referenced through the package scope.
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        gap_q, gap_d;
    logic              hold_full_q, hold_full_d;
    logic [CODE_W:1]   hold_q, hold_d;
    logic [CODE_W:1]   code_q, code_d;
    logic [FL-1:0]     frame_q, frame_d;

    logic [CODE_W:1]   enc_code;
    logic              accept;
    logic              beat;
    logic              eof_bit;
    logic              load;
    logic              direct;
    logic [CODE_W:1]   load_code;

    hamming_parity_gen u_parity (
        .data_i (data_i),
        .code_o (enc_code)
    );

    // Lay the codeword out in transmission order so the counter indexes it directly.
    function automatic logic [FL-1:0] build_frame(input logic [CODE_W:1] c);
        logic [FL:1]   ext;
        logic [FL-1:0] f;
`ifdef HAMMING_SECDED_EN
        ext = {^c, c};
`else
        ext = c;
`endif
        for (int i = 0; i < FL; i++) begin
            f[i] = MSB_FIRST ? ext[FL - i] : ext[i + 1];
        end
        return f;
    endfunction

    assign accept     = valid_i & ~hold_full_q;
    assign tx_valid_o = (state_q == SHIFT);
    assign beat       = tx_valid_o & tx_ready_i;
    assign eof_bit    = tx_valid_o & (cnt_q == LAST_CNT);

    // Next-state logic: frame sequencing, holding-register fill/drain and reloads.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        code_d      = code_q;
        frame_d     = frame_q;
        load        = 1'b0;
        direct      = 1'b0;
        load_code   = hold_q;

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end else if (accept) begin
                    // Idle word bypasses the hold so sof appears the next cycle.
                    load      = 1'b1;
                    direct    = 1'b1;
                    load_code = enc_code;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (eof_bit) begin
                        if (GAP > 0) begin
                            state_d = hamming_pkg::GAP;
                            gap_d   = '0;
                        end else if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            hamming_pkg::GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GAP_LAST) begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload and accept never coincide on the hold: ready_o is low while it is full.
        if (load && !direct) begin
            hold_full_d = 1'b0;
        end
        if (accept && !direct) begin
            hold_full_d = 1'b1;
            hold_d      = enc_code;
        end

        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            code_d  = load_code;
            frame_d = build_frame(load_code);
        end
    end

    // State and datapath registers; reset aborts any frame and drops the held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            hold_full_q <= 1'b0;
            // NOTE: data registers are reset too so code_o and tx_bit_o read 0 after reset.
            hold_q      <= '0;
            code_q      <= '0;
            frame_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            code_q      <= code_d;
            frame_q     <= frame_d;
        end
    end

    assign ready_o  = ~hold_full_q;
    assign tx_bit_o = tx_valid_o & frame_q[cnt_q];
    assign tx_sof_o = tx_valid_o & (cnt_q == 4'd0);
    assign tx_eof_o = eof_bit;
    assign code_o   = code_q;
    assign busy_o   = (state_q != IDLE) | hold_full_q;

endmodule
